// File: rtl/parity_checker_pkg.sv
// Shared definitions for the serial parity receiver: FSM state encoding
// and the bit-counter width helper.
package parity_checker_pkg;

  // 2'd3 is unused; the controller recovers from it to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;

  // Counter must represent 0..w inclusive so it can stop at w.
  function automatic int cnt_width(input int w);
    return (w < 1) ? 1 : $clog2(w + 1);
  endfunction

endpackage

// File: rtl/parity_checker_control.sv
// Frame-sequencing FSM for the parity receiver. Produces the datapath
// strobes (counter clear, shift/accumulate enable, result load) and the
// registered busy/done status.
module control_checker
  import parity_checker_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic init,
  input  logic s_valid,
  input  logic cnt_full,
  output logic cnt_clr,
  output logic shift_en,
  output logic acc_en,
  output logic load,
  output logic busy,
  output logic done
);

  state_t state;

  // Datapath strobes decoded from the current state and the serial inputs.
  always_comb begin
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    acc_en   = 1'b0;
    load     = 1'b0;
    if ((state == ST_IDLE || state == ST_DONE) && init) begin
      cnt_clr = 1'b1;
    end
    if (state == ST_RECV && s_valid) begin
      shift_en = !cnt_full;
      acc_en   = !cnt_full;
      load     = cnt_full;
    end
  end

  // State register with busy/done registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (init) begin
            state <= ST_RECV;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        ST_RECV: begin
          // The parity bit arrives once every data bit has been counted.
          if (s_valid && cnt_full) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (init) begin
            state <= ST_RECV;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/parity_checker.sv
// Serial parity receiver: deserializes an LSB-first WIDTH-bit word followed
// by an even-parity bit, recomputes parity on the fly and reports the word,
// the computed parity and a mismatch flag when the frame completes.
module parity_checker
  import parity_checker_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             s_in,
  input  logic             s_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             par_calc,
  output logic             par_err,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = cnt_width(WIDTH);

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shreg;
  logic             acc;
  logic             cnt_full;
  logic             cnt_clr;
  logic             shift_en;
  logic             acc_en;
  logic             load;

  // New bits enter at the MSB so the first received bit ends up at bit 0.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v,
                                                input logic b);
    logic [WIDTH-1:0] r;
    r = v >> 1;
    r[WIDTH-1] = b;
    return r;
  endfunction

  assign cnt_full = (cnt == CNT_W'(WIDTH));

  control_checker u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .init     (init),
    .s_valid  (s_valid),
    .cnt_full (cnt_full),
    .cnt_clr  (cnt_clr),
    .shift_en (shift_en),
    .acc_en   (acc_en),
    .load     (load),
    .busy     (busy),
    .done     (done)
  );

  // Frame collection: counter, shift register and running parity.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt   <= '0;
      shreg <= '0;
      acc   <= 1'b0;
    end else if (cnt_clr) begin
      cnt   <= '0;
      shreg <= '0;
      acc   <= 1'b0;
    end else begin
      if (shift_en) begin
        shreg <= shift_in(shreg, s_in);
        cnt   <= cnt + CNT_W'(1);
      end
      if (acc_en) begin
        acc <= acc ^ s_in;
      end
    end
  end

  // Result registers: updated only when the parity bit is sampled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_out <= '0;
      par_calc <= 1'b0;
      par_err  <= 1'b0;
    end else if (load) begin
      data_out <= shreg;
      par_calc <= acc;
      par_err  <= acc ^ s_in;
    end
  end

endmodule
